// File: rtl/keypad_scan_pkg.sv
// rtl/keypad_scan_pkg.sv - shared constants and frame-result types for keypad_scan
package keypad_scan_pkg;

  localparam logic [3:0] KEY_CLEAR = 4'd10;
  localparam logic [3:0] COL_RESET = 4'b1110;

  typedef enum logic [1:0] {
    RES_NONE    = 2'd0,
    RES_KEY     = 2'd1,
    RES_INVALID = 2'd2
  } res_kind_t;

  typedef struct packed {
    res_kind_t  kind;
    logic [3:0] idx;
  } frame_res_t;

  // lows[row*4+col] is set where a row read low while that column was strobed
  function automatic frame_res_t classify(input logic [15:0] lows);
    frame_res_t res;
    logic [1:0] hits;
    res.kind = RES_NONE;
    res.idx  = 4'd0;
    hits     = 2'd0;
    for (int i = 0; i < 16; i++) begin
      if (lows[4'(i)]) begin
        if (hits != 2'd2) hits = hits + 2'd1;
        res.idx = 4'(i);
      end
    end
    if (hits == 2'd1) res.kind = RES_KEY;
    else if (hits == 2'd2) res.kind = RES_INVALID;
    return res;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// rtl/keypad_scan_if.sv - keypad matrix and key-report signal bundle
interface keypad_scan_if;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] digits;

  modport master (input row, output col, output key_valid, output key_code, output digits);
  modport slave  (output row, input col, input key_valid, input key_code, input digits);
endinterface

// File: rtl/keypad_scan_key_debounce.sv
// rtl/keypad_scan_key_debounce.sv - frame stability counter and press/release FSM
module key_debounce
  import keypad_scan_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_done,
  input  frame_res_t frame_res,
  output logic       accept,
  output logic [3:0] accept_idx
);

  typedef enum logic {ST_RELEASED, ST_PRESSED} state_t;

  localparam logic [3:0] DB_MAX = 4'(DEBOUNCE);

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic       prev_key, cur_key, same;
  logic [3:0] prev_idx;

  // INVALID frames collapse onto NONE so ghosting reads as a release
  assign cur_key    = (frame_res.kind == RES_KEY);
  assign same       = (cur_key == prev_key) && (!cur_key || (frame_res.idx == prev_idx));
  assign accept_idx = frame_res.idx;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_RELEASED;
      cnt      <= 4'd0;
      prev_key <= 1'b0;
      prev_idx <= 4'd0;
    end else begin
      state <= state_next;
      if (frame_done) begin
        cnt      <= cnt_next;
        prev_key <= cur_key;
        prev_idx <= cur_key ? frame_res.idx : 4'd0;
      end
    end
  end

  always_comb begin
    cnt_next   = 4'd1;
    state_next = state;
    accept     = 1'b0;
    if (same) cnt_next = (cnt >= DB_MAX) ? DB_MAX : cnt + 4'd1;
    if (frame_done && (cnt_next == DB_MAX)) begin
      case (state)
        ST_RELEASED: begin
          if (cur_key) begin
            state_next = ST_PRESSED;
            accept     = 1'b1;
          end
        end
        ST_PRESSED: begin
          if (!cur_key) state_next = ST_RELEASED;
        end
        default: state_next = ST_RELEASED;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 keypad column scanner with debounce and BCD entry register
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int SCAN_DIV = 125000,
  parameter int DEBOUNCE = 4
) (
  input logic          clock,
  input logic          reset,
  keypad_scan_if.master bus
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [3:0]       row_s1, row_s2;
  logic [DIV_W-1:0] div;
  logic             tick, frame_done, accept;
  logic [1:0]       col_idx;
  logic [3:0]       col_q, code_q, accept_idx;
  logic             key_valid_q;
  logic [15:0]      lows_acc, lows_now, digits_q;
  frame_res_t       frame_res;

  assign tick       = (div == DIV_LAST);
  assign frame_done = tick && (col_idx == 2'd3);

  // Merge the current column's sample so the column-3 tick sees the whole frame
  always_comb begin
    lows_now = lows_acc;
    for (int r = 0; r < 4; r++) begin
      lows_now[{2'(r), col_idx}] = ~row_s2[r];
    end
  end

  assign frame_res = classify(lows_now);

  key_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
    .clock      (clock),
    .reset      (reset),
    .frame_done (frame_done),
    .frame_res  (frame_res),
    .accept     (accept),
    .accept_idx (accept_idx)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      row_s1      <= 4'hF;
      row_s2      <= 4'hF;
      div         <= '0;
      col_q       <= COL_RESET;
      col_idx     <= 2'd0;
      lows_acc    <= 16'h0000;
      key_valid_q <= 1'b0;
      code_q      <= 4'd0;
      digits_q    <= 16'h0000;
    end else begin
      row_s1      <= bus.row;
      row_s2      <= row_s1;
      key_valid_q <= accept;
      div         <= tick ? '0 : div + DIV_W'(1);
      if (tick) begin
        col_q    <= {col_q[2:0], col_q[3]};
        col_idx  <= col_idx + 2'd1;
        lows_acc <= frame_done ? 16'h0000 : lows_now;
      end
      if (accept) begin
        code_q <= accept_idx;
        if (accept_idx == KEY_CLEAR) digits_q <= 16'h0000;
        else if (accept_idx <= 4'd9) digits_q <= {digits_q[11:0], accept_idx};
      end
    end
  end

  assign bus.col       = col_q;
  assign bus.key_valid = key_valid_q;
  assign bus.key_code  = code_q;
  assign bus.digits    = digits_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - self-checking bench for keypad_scan
module tb_keypad_scan;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 2;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] keys  = 16'h0000;
  int          n_cmp = 0;
  int          n_bad = 0;

  keypad_scan_if kif();

  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (kif.master)
  );

  always #5 clock = ~clock;

  // Keypad: a pressed key pulls its row low while its column is strobed
  always_comb begin
    kif.row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4'(r * 4 + c)] && !kif.col[2'(c)]) kif.row[2'(r)] = 1'b0;
  end

  typedef struct {
    logic [15:0] keys;
    int          frames;
    int          pulses;
    logic [3:0]  code;
    logic [15:0] digits;
  } vec_t;

  vec_t tbl[$];

  // Reference: entered number kept as a decimal value, previous frame as key index or -1
  int m_prev    = -1;
  int m_run     = 0;
  bit m_pressed = 1'b0;
  int m_code    = 0;
  int m_value   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] k1(input int i);
    logic [15:0] one;
    one = 16'h0001;
    return one << i;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] b;
    int x;
    b = 16'h0000;
    x = v;
    for (int i = 0; i < 4; i++) begin
      b[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return b;
  endfunction

  task automatic model_reset();
    m_prev    = -1;
    m_run     = 0;
    m_pressed = 1'b0;
    m_code    = 0;
    m_value   = 0;
  endtask

  task automatic model_frame(input logic [15:0] k, output bit pulse);
    int res;
    res   = ($countones(k) == 1) ? $clog2(k) : -1;
    m_run = (res == m_prev) ? ((m_run >= DEBOUNCE) ? DEBOUNCE : m_run + 1) : 1;
    m_prev = res;
    pulse  = 1'b0;
    if (m_run == DEBOUNCE) begin
      if (!m_pressed && res >= 0) begin
        m_pressed = 1'b1;
        pulse     = 1'b1;
        m_code    = res;
        if (res == 10) m_value = 0;
        else if (res < 10) m_value = (m_value * 10 + res) % 10000;
      end else if (m_pressed && res < 0) begin
        m_pressed = 1'b0;
      end
    end
  endtask

  // Holds k for one frame, starting just after a frame boundary
  task automatic run_frame(input logic [15:0] k, output int pulses);
    bit         exp_pulse;
    logic [3:0] ce;
    keys   = k;
    pulses = 0;
    model_frame(k, exp_pulse);
    for (int i = 1; i <= FRAME; i++) begin
      @(posedge clock);
      #1;
      if (kif.key_valid) pulses++;
      ce = ~(4'b0001 << ((i / SCAN_DIV) % 4));
      check("col", kif.col, ce);
      if (i < FRAME) check("kv_idle", kif.key_valid, 0);
    end
    check("kv_frame", kif.key_valid, exp_pulse);
    check("code_model", kif.key_code, m_code);
    check("digits_model", kif.digits, to_bcd(m_value));
  endtask

  initial begin
    int          p, tot, sel, nf;
    bit          dummy;
    logic [15:0] rk;

    tbl.push_back('{k1(5), 4, 1, 4'd5, 16'h0005});
    tbl.push_back('{16'h0000, 3, 0, 4'd5, 16'h0005});
    tbl.push_back('{k1(1), 3, 1, 4'd1, 16'h0051});
    tbl.push_back('{16'h0000, 3, 0, 4'd1, 16'h0051});
    tbl.push_back('{k1(2), 3, 1, 4'd2, 16'h0512});
    tbl.push_back('{16'h0000, 3, 0, 4'd2, 16'h0512});
    tbl.push_back('{k1(3), 3, 1, 4'd3, 16'h5123});
    tbl.push_back('{16'h0000, 3, 0, 4'd3, 16'h5123});
    tbl.push_back('{k1(4), 3, 1, 4'd4, 16'h1234});
    tbl.push_back('{16'h0000, 3, 0, 4'd4, 16'h1234});
    tbl.push_back('{k1(7), 3, 1, 4'd7, 16'h2347});
    tbl.push_back('{16'h0000, 3, 0, 4'd7, 16'h2347});
    tbl.push_back('{k1(10), 3, 1, 4'd10, 16'h0000});
    tbl.push_back('{16'h0000, 3, 0, 4'd10, 16'h0000});
    tbl.push_back('{k1(14), 3, 1, 4'd14, 16'h0000});
    tbl.push_back('{16'h0000, 3, 0, 4'd14, 16'h0000});
    tbl.push_back('{k1(9), 1, 0, 4'd14, 16'h0000});
    tbl.push_back('{16'h0000, 2, 0, 4'd14, 16'h0000});
    tbl.push_back('{k1(0) | k1(5), 3, 0, 4'd14, 16'h0000});
    tbl.push_back('{k1(5), 3, 1, 4'd5, 16'h0005});
    tbl.push_back('{16'h0000, 3, 0, 4'd5, 16'h0005});
    tbl.push_back('{k1(2), 3, 1, 4'd2, 16'h0052});
    tbl.push_back('{k1(8), 3, 0, 4'd2, 16'h0052});
    tbl.push_back('{16'h0000, 3, 0, 4'd2, 16'h0052});

    keys = k1(5);
    repeat (3) @(posedge clock);
    #1;
    check("rst_col", kif.col, 4'b1110);
    check("rst_kv", kif.key_valid, 0);
    check("rst_code", kif.key_code, 0);
    check("rst_digits", kif.digits, 16'h0000);
    reset = 1'b0;

    for (int v = 0; v < tbl.size(); v++) begin
      tot = 0;
      for (int f = 0; f < tbl[v].frames; f++) begin
        run_frame(tbl[v].keys, p);
        tot += p;
      end
      check($sformatf("vec%0d_pulses", v), tot, tbl[v].pulses);
      check($sformatf("vec%0d_code", v), kif.key_code, tbl[v].code);
      check($sformatf("vec%0d_digits", v), kif.digits, tbl[v].digits);
    end

    // Key 6 bounces on alternate ticks for one frame, then is held
    tot = 0;
    for (int i = 1; i <= FRAME; i++) begin
      if ((i - 1) % SCAN_DIV == 0) keys = ((((i - 1) / SCAN_DIV) % 2) == 0) ? k1(6) : 16'h0000;
      @(posedge clock);
      #1;
      if (kif.key_valid) tot++;
    end
    check("bounce_frame_pulses", tot, 0);
    model_frame(k1(6), dummy);
    for (int f = 0; f < 2; f++) begin
      run_frame(k1(6), p);
      tot += p;
    end
    check("bounce_pulses", tot, 1);
    check("bounce_code", kif.key_code, 4'd6);
    check("bounce_digits", kif.digits, 16'h0526);
    repeat (3) run_frame(16'h0000, p);

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 3);
      rk  = 16'h0000;
      if (sel == 1 || sel == 2) rk = k1($urandom_range(0, 15));
      if (sel == 3) rk = k1($urandom_range(0, 15)) | k1($urandom_range(0, 15));
      nf = $urandom_range(1, 4);
      for (int f = 0; f < nf; f++) run_frame(rk, p);
    end

    // Reset pulse in the middle of a frame while key 3 is held
    repeat (3) run_frame(k1(3), p);
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("mid_rst_col", kif.col, 4'b1110);
    check("mid_rst_kv", kif.key_valid, 0);
    check("mid_rst_code", kif.key_code, 0);
    check("mid_rst_digits", kif.digits, 16'h0000);
    model_reset();
    tot = 0;
    for (int f = 0; f < 3; f++) begin
      run_frame(k1(3), p);
      tot += p;
    end
    check("after_rst_pulses", tot, 1);
    check("after_rst_code", kif.key_code, 4'd3);
    check("after_rst_digits", kif.digits, 16'h0003);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scans a 4×4 active-low matrix keypad and debounces it, reporting each new key press once. It also keeps a 4-digit BCD entry register. This is the input counterpart of the 4-digit seven-segment display driver: it drives column strobes and reads rows. Its `digits` output feeds the display driver's digit inputs directly, so typed numbers appear on the panel.

## Interface
- `SCAN_DIV`, default 125000: clock cycles per column dwell. One column advance per tick.
- `DEBOUNCE`, default 4: consecutive identical scan frames required to accept a press or a release. Legal range is 1..15.
- `clock`  in  1: system clock. This is the single clock domain.
- `reset`  in  1: synchronous, active-high reset.
- `row`  in  4: keypad rows, active-low with external pull-ups. Treated as already synchronised; the implementation adds a 2-flop synchroniser regardless.
- `col`  out  4: column strobes, active-low, exactly one bit low at a time.
- `key_valid`  out  1: one-cycle pulse when a new key press is accepted.
- `key_code`  out  4: key index = row*4 + col. Held stable until the next `key_valid`.
- `digits`  out  16: four BCD digits. Digit 0 is in [3:0] and is the newest.

## Operation
- Divider counts 0..SCAN_DIV-1. A tick occurs when it equals SCAN_DIV-1.
- On each tick:
  - Sample the synchronised `row` for the column currently driven.
  - Advance `col` through 1110 → 1101 → 1011 → 0111 → 1110.
- A frame is 4 ticks and ends on the column-3 tick. Frame result is one of:
  - KEY(index): exactly one low row bit across all four columns.
  - NONE: no low bits.
  - INVALID: two or more low bits (ghosting or multi-press). Treated as NONE for release counting and never accepted as a key.
- Stability counter: increments when the frame result equals the previous frame result, saturating at DEBOUNCE. Otherwise it loads 1.
- State machine:
  - RELEASED → PRESSED when the counter reaches DEBOUNCE with a KEY result. Same edge: pulse `key_valid`, load `key_code`, apply the digit action.
  - PRESSED → RELEASED when the counter reaches DEBOUNCE with a NONE or INVALID result. No pulse.
  - A key held in PRESSED never repeats.
  - A change directly from one key to a different key (no clean release frames) does not produce a pulse until a release is accepted.
- Digit actions:
  - Index 0–9: `digits` ← {digits[11:0], index}. The oldest digit is discarded.
  - Index 10: `digits` ← 0.
  - Index 11–15: reported on `key_code` only; `digits` is unchanged.

## Timing
- Reset values:
  - `col` = 4'b1110, `key_valid` = 0, `key_code` = 0, `digits` = 16'h0000.
  - Divider 0, state RELEASED, stability counter 0, previous result NONE.
  - Row synchroniser flops = 4'b1111.
- First tick is on the SCAN_DIV-th rising edge after `reset` deasserts.
- Minimum press latency from a stable press is DEBOUNCE frames, i.e. 4·SCAN_DIV·DEBOUNCE cycles, plus synchroniser delay if the press begins mid-frame.
- `key_valid`, `key_code` and `digits` all update on the same edge (registered, no combinational paths from `row`).
- Reset mid-operation: all state is restored at once. A key held through reset is accepted once after DEBOUNCE frames.
- `col` changes only on a tick. It is glitch-free because it is a registered one-hot-cold vector.

## Structure
- The shared package holds:
  - Constant KEY_CLEAR = 4'd10.
  - Column strobe reset value 4'b1110.
  - The frame-result encoding: 2-bit kind {NONE, KEY, INVALID} plus 4-bit index.
- One sub-module is natural: `key_debounce`. It takes the frame result and a frame-done strobe and outputs the accepted-press pulse and index. It contains the stability counter and the RELEASED/PRESSED FSM.
- The top level keeps the divider, column scan, frame accumulation and digit register.

## Test plan
Benches use SCAN_DIV=4 and DEBOUNCE=2. The keypad model pulls a row low while its column is low.

- Hold key 5 (row 1, col 1) from reset → `key_valid` pulses once at edge 32 after reset release plus synchroniser delay. `key_code`=5 and `digits`=16'h0005. No further pulses while held.
- Press and release 1, 2, 3, 4, 7 in turn, each ≥3 frames with ≥3 release frames → `digits`=16'h2347. Exactly 5 pulses.
- Press key 10 after the previous sequence → `digits`=16'h0000, `key_code`=10. Then press 14 → `key_code`=14, `digits` unchanged.
- Key 6 bounces (toggling every tick for 1 frame) then holds 2 frames → exactly one pulse. A single-frame glitch of key 9 → no pulse.
- Keys 0 and 5 held simultaneously → no pulse. Release 0 while keeping 5 → 5 accepted after 2 frames, since INVALID counts as released.
- Assert `reset` for 1 cycle while key 3 is held in PRESSED → outputs return to reset values, `col`=1110. Key 3 is reported again after 2 frames.
